// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu -- multiply/divide unit with architectural HI/LO registers.
//
// Multiplies (mult, multu and the optional multiply-accumulate family) hold
// busy for 5 cycles, divides (div, divu) for 10. HI/LO are written on the
// edge that ends the last busy cycle. mthi/mtlo write HI/LO immediately,
// with no busy cycles.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-low reset
//   req         flush; blocks acceptance of the instruction presented this
//               cycle (does not cancel an operation already running)
//   start       instruction valid strobe
//   op[3:0]     0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//               7 madd, 8 maddu, 9 msub, 10 msubu, 11-15 none
//   A, B        rs / rt operand values
//   busy        multi-cycle operation in progress
//   HI, LO      architectural HI/LO registers
//
// Configuration
//   MDU_MADD_EN  when defined, ops 7-10 ({HI,LO} +=/-= A*B) are accepted;
//                otherwise they are treated as "none".
// ---------------------------------------------------------------------------
module mdu #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              start,
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   output logic              busy,
   output logic [DATA_W-1:0] HI,
   output logic [DATA_W-1:0] LO
);

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;

   // Counter load values: cnt counts down to zero, and the edge seen with
   // cnt==0 is the one that ends the final busy cycle.
   localparam logic [3:0] MUL_LOAD = 4'd4;   // 5 busy cycles
   localparam logic [3:0] DIV_LOAD = 4'd9;   // 10 busy cycles

   localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // Arithmetic helpers
   // ------------------------------------------------------------------

   // Opcodes that can be accepted in this build.
   function automatic logic op_valid(input logic [3:0] o);
`ifdef MDU_MADD_EN
      op_valid = (o >= OP_MULT) && (o <= OP_MSUBU);
`else
      op_valid = (o >= OP_MULT) && (o <= OP_MTLO);
`endif
   endfunction

   // Full-width product. Operands are extended to 2*DATA_W (sign or zero)
   // so that the truncated 2*DATA_W product is exact in both modes.
   function automatic logic [2*DATA_W-1:0] mul_full(
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b,
      input logic              sgn
   );
      logic signed [2*DATA_W-1:0] ea;
      logic signed [2*DATA_W-1:0] eb;
      logic signed [2*DATA_W-1:0] p;
      ea = signed'({{DATA_W{sgn & a[DATA_W-1]}}, a});
      eb = signed'({{DATA_W{sgn & b[DATA_W-1]}}, b});
      p  = ea * eb;
      mul_full = p;
   endfunction

   // Division returning {remainder, quotient}. Signed division runs on
   // magnitudes and then restores signs: the quotient truncates toward zero
   // and the remainder takes the sign of the dividend. Working on unsigned
   // magnitudes makes the most-negative / -1 case fall out naturally as
   // quotient = most-negative, remainder = 0. A zero divisor is replaced by
   // one so the operator never sees it; the caller discards that result.
   function automatic logic [2*DATA_W-1:0] div_full(
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b,
      input logic              sgn
   );
      logic              neg_a;
      logic              neg_b;
      logic [DATA_W-1:0] ma;
      logic [DATA_W-1:0] mb;
      logic [DATA_W-1:0] q;
      logic [DATA_W-1:0] r;
      neg_a = sgn & a[DATA_W-1];
      neg_b = sgn & b[DATA_W-1];
      ma    = neg_a ? -a : a;
      mb    = neg_b ? -b : b;
      if (mb == '0) begin
         mb = ONE;
      end
      q = ma / mb;
      r = ma % mb;
      if (neg_a ^ neg_b) begin
         q = -q;
      end
      if (neg_a) begin
         r = -r;
      end
      div_full = {r, q};
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t            state_q, state_d;
   logic [3:0]        cnt_q,   cnt_d;
   logic [3:0]        op_q,    op_d;
   logic [DATA_W-1:0] a_q,     a_d;
   logic [DATA_W-1:0] b_q,     b_d;
   logic [DATA_W-1:0] hi_q,    hi_d;
   logic [DATA_W-1:0] lo_q,    lo_d;
   logic              busy_q,  busy_d;

   logic              accept;
   logic [2*DATA_W-1:0] acc;
   logic [2*DATA_W-1:0] prod;
   logic [2*DATA_W-1:0] quot_rem;
   logic [2*DATA_W-1:0] result;
   logic                result_we;

   // Result path: evaluated from the captured operands. {HI,LO} read here is
   // the value at completion; nothing can write HI/LO while RUN.
   always_comb begin
      acc       = {hi_q, lo_q};
      prod      = mul_full(a_q, b_q,
                           (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB));
      quot_rem  = div_full(a_q, b_q, op_q == OP_DIV);
      result    = acc;
      result_we = 1'b0;
      case (op_q)
         OP_MULT, OP_MULTU: begin
            result    = prod;
            result_we = 1'b1;
         end
         OP_DIV, OP_DIVU: begin
            result    = quot_rem;
            // Divide by zero still takes the full latency but leaves HI/LO.
            result_we = (b_q != '0);
         end
         OP_MADD, OP_MADDU: begin
            result    = acc + prod;
            result_we = 1'b1;
         end
         OP_MSUB, OP_MSUBU: begin
            result    = acc - prod;
            result_we = 1'b1;
         end
         default: begin
            result    = acc;
            result_we = 1'b0;
         end
      endcase
   end

   assign accept = (state_q == S_IDLE) && start && !req && !busy_q && op_valid(op);

   // Next-state logic. req is only consulted through accept, so a flush that
   // arrives while RUN leaves the running operation alone.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (op)
                  OP_MTHI: hi_d = A;
                  OP_MTLO: lo_d = A;
                  default: begin
                     op_d    = op;
                     a_d     = A;
                     b_d     = B;
                     state_d = S_RUN;
                     busy_d  = 1'b1;
                     cnt_d   = ((op == OP_DIV) || (op == OP_DIVU)) ? DIV_LOAD : MUL_LOAD;
                  end
               endcase
            end
         end
         S_RUN: begin
            if (cnt_q == 4'd0) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               if (result_we) begin
                  hi_d = result[2*DATA_W-1:DATA_W];
                  lo_d = result[DATA_W-1:0];
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Registers. Reset wins over everything, including an operation in RUN,
   // which is abandoned without touching HI/LO.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         op_q    <= OP_NONE;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
      end
   end

   assign busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// ---------------------------------------------------------------------------
// tb_mdu -- directed self-checking bench for mdu.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mdu;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUBU = 4'd10;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        start;
   logic [3:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mdu dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .start (start),
      .op    (op),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .HI    (HI),
      .LO    (LO)
   );

   // Present one instruction for exactly one rising edge.
   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic r);
      @(negedge clk);
      start = 1'b1; op = o; A = a; B = b; req = r;
      @(posedge clk);
      #1;
      start = 1'b0; op = OP_NONE; req = 1'b0;
   endtask

   // Count busy cycles after issue; returns at the first negedge with busy=0.
   task automatic wait_idle(output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy !== 1'b1) break;
         n++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (HI !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h want=00000000", HI); end
      checks++; if (LO !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h want=00000000", LO); end
      reset = 1'b1;
   endtask

   task automatic test_mult;
      int n;
      issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
      wait_idle(n);
      checks++; if (n != 5) begin failures++; $display("FAIL mult_busy got=%0d want=5", n); end
      checks++; if (HI !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h want=ffffffff", HI); end
      checks++; if (LO !== 32'hFFFFFFFA) begin failures++; $display("FAIL mult_lo got=%h want=fffffffa", LO); end
      // 0xFFFFFFFE * 3 unsigned = 0x2_FFFFFFFA
      issue(OP_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0);
      wait_idle(n);
      checks++; if (n != 5) begin failures++; $display("FAIL multu_busy got=%0d want=5", n); end
      checks++; if (HI !== 32'h00000002) begin failures++; $display("FAIL multu_hi got=%h want=00000002", HI); end
      checks++; if (LO !== 32'hFFFFFFFA) begin failures++; $display("FAIL multu_lo got=%h want=fffffffa", LO); end
   endtask

   task automatic test_div;
      int n;
      issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
      wait_idle(n);
      checks++; if (n != 10) begin failures++; $display("FAIL divu_busy got=%0d want=10", n); end
      checks++; if (LO !== 32'd14) begin failures++; $display("FAIL divu_lo got=%h want=0000000e", LO); end
      checks++; if (HI !== 32'd2) begin failures++; $display("FAIL divu_hi got=%h want=00000002", HI); end
      issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
      wait_idle(n);
      checks++; if (n != 10) begin failures++; $display("FAIL div_busy got=%0d want=10", n); end
      checks++; if (LO !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h want=fffffffd", LO); end
      checks++; if (HI !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h want=ffffffff", HI); end
      issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      wait_idle(n);
      checks++; if (LO !== 32'h80000000) begin failures++; $display("FAIL div_ovf_lo got=%h want=80000000", LO); end
      checks++; if (HI !== 32'h00000000) begin failures++; $display("FAIL div_ovf_hi got=%h want=00000000", HI); end
   endtask

   task automatic test_div_zero;
      int n;
      issue(OP_MTHI, 32'h12345678, 32'h0, 1'b0);
      wait_idle(n);
      checks++; if (n != 0) begin failures++; $display("FAIL mthi_busy got=%0d want=0", n); end
      checks++; if (HI !== 32'h12345678) begin failures++; $display("FAIL mthi_hi got=%h want=12345678", HI); end
      issue(OP_MTLO, 32'hCAFEF00D, 32'h0, 1'b0);
      wait_idle(n);
      checks++; if (LO !== 32'hCAFEF00D) begin failures++; $display("FAIL mtlo_lo got=%h want=cafef00d", LO); end
      issue(OP_DIV, 32'd55, 32'd0, 1'b0);
      wait_idle(n);
      checks++; if (n != 10) begin failures++; $display("FAIL divz_busy got=%0d want=10", n); end
      checks++; if (HI !== 32'h12345678) begin failures++; $display("FAIL divz_hi got=%h want=12345678", HI); end
      checks++; if (LO !== 32'hCAFEF00D) begin failures++; $display("FAIL divz_lo got=%h want=cafef00d", LO); end
   endtask

   task automatic test_flush;
      int n;
      issue(OP_MULT, 32'd6, 32'd7, 1'b1);
      wait_idle(n);
      checks++; if (n != 0) begin failures++; $display("FAIL flush_busy got=%0d want=0", n); end
      checks++; if (HI !== 32'h12345678) begin failures++; $display("FAIL flush_hi got=%h want=12345678", HI); end
      checks++; if (LO !== 32'hCAFEF00D) begin failures++; $display("FAIL flush_lo got=%h want=cafef00d", LO); end
      // Flush raised on busy cycle 2 must not cancel the running mult.
      issue(OP_MULT, 32'd6, 32'd7, 1'b0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy !== 1'b1) break;
         n++;
         req = (n >= 2);
      end
      req = 1'b0;
      checks++; if (n != 5) begin failures++; $display("FAIL flush_late_busy got=%0d want=5", n); end
      checks++; if (HI !== 32'h0) begin failures++; $display("FAIL flush_late_hi got=%h want=00000000", HI); end
      checks++; if (LO !== 32'd42) begin failures++; $display("FAIL flush_late_lo got=%h want=0000002a", LO); end
   endtask

   task automatic test_reset_abort;
      issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
      repeat (4) @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_c4 got=%b want=1", busy); end
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
      checks++; if (HI !== 32'h0) begin failures++; $display("FAIL abort_hi got=%h want=00000000", HI); end
      checks++; if (LO !== 32'h0) begin failures++; $display("FAIL abort_lo got=%h want=00000000", LO); end
      repeat (15) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_late_busy got=%b want=0", busy); end
      checks++; if (HI !== 32'h0) begin failures++; $display("FAIL abort_late_hi got=%h want=00000000", HI); end
      checks++; if (LO !== 32'h0) begin failures++; $display("FAIL abort_late_lo got=%h want=00000000", LO); end
   endtask

   task automatic test_back_to_back;
      int n;
      // 5 * -3 = -15; a divu strobed on busy cycle 2 must be dropped.
      issue(OP_MULT, 32'd5, 32'hFFFFFFFD, 1'b0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy !== 1'b1) break;
         n++;
         if (n == 2) begin start = 1'b1; op = OP_DIVU; A = 32'd100; B = 32'd7; end
         else begin start = 1'b0; op = OP_NONE; end
      end
      start = 1'b0; op = OP_NONE;
      checks++; if (n != 5) begin failures++; $display("FAIL b2b_busy got=%0d want=5", n); end
      checks++; if (HI !== 32'hFFFFFFFF) begin failures++; $display("FAIL b2b_hi got=%h want=ffffffff", HI); end
      checks++; if (LO !== 32'hFFFFFFF1) begin failures++; $display("FAIL b2b_lo got=%h want=fffffff1", LO); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_after_busy got=%b want=0", busy); end
   endtask

   task automatic test_invalid_op;
      int n;
      issue(OP_NONE, 32'd9, 32'd9, 1'b0);
      wait_idle(n);
      checks++; if (n != 0) begin failures++; $display("FAIL op0_busy got=%0d want=0", n); end
      issue(4'd11, 32'd9, 32'd9, 1'b0);
      wait_idle(n);
      checks++; if (n != 0) begin failures++; $display("FAIL op11_busy got=%0d want=0", n); end
      checks++; if (HI !== 32'hFFFFFFFF) begin failures++; $display("FAIL op11_hi got=%h want=ffffffff", HI); end
      checks++; if (LO !== 32'hFFFFFFF1) begin failures++; $display("FAIL op11_lo got=%h want=fffffff1", LO); end
   endtask

   task automatic test_madd;
      int n;
      issue(OP_MTHI, 32'h0, 32'h0, 1'b0);
      issue(OP_MTLO, 32'hFFFFFFFF, 32'h0, 1'b0);
      issue(OP_MADDU, 32'd1, 32'd1, 1'b0);
      wait_idle(n);
`ifdef MDU_MADD_EN
      checks++; if (n != 5) begin failures++; $display("FAIL maddu_busy got=%0d want=5", n); end
      checks++; if (HI !== 32'h1) begin failures++; $display("FAIL maddu_hi got=%h want=00000001", HI); end
      checks++; if (LO !== 32'h0) begin failures++; $display("FAIL maddu_lo got=%h want=00000000", LO); end
      issue(OP_MSUBU, 32'd1, 32'd1, 1'b0);
      wait_idle(n);
      checks++; if (HI !== 32'h0) begin failures++; $display("FAIL msubu_hi got=%h want=00000000", HI); end
      checks++; if (LO !== 32'hFFFFFFFF) begin failures++; $display("FAIL msubu_lo got=%h want=ffffffff", LO); end
`else
      checks++; if (n != 0) begin failures++; $display("FAIL maddu_off_busy got=%0d want=0", n); end
      checks++; if (HI !== 32'h0) begin failures++; $display("FAIL maddu_off_hi got=%h want=00000000", HI); end
      checks++; if (LO !== 32'hFFFFFFFF) begin failures++; $display("FAIL maddu_off_lo got=%h want=ffffffff", LO); end
      issue(OP_MSUBU, 32'd1, 32'd1, 1'b0);
      wait_idle(n);
      checks++; if (n != 0) begin failures++; $display("FAIL msubu_off_busy got=%0d want=0", n); end
      checks++; if (LO !== 32'hFFFFFFFF) begin failures++; $display("FAIL msubu_off_lo got=%h want=ffffffff", LO); end
`endif
   endtask

   initial begin
      reset = 1'b0; req = 1'b0; start = 1'b0; op = OP_NONE; A = '0; B = '0;
      test_reset;
      test_mult;
      test_div;
      test_div_zero;
      test_flush;
      test_reset_abort;
      test_back_to_back;
      test_invalid_op;
      test_madd;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
